// File: rtl/tia_dl_pkg.sv
// Shared constants and helpers for the tia_dl latch bank.
// Optional feature macro: TIA_DL_BANK_EDGE_EN (rising-edge capture of in).
package tia_dl_pkg;

    localparam int N_DEF     = 4;
    localparam int CNT_W_DEF = 8;

    // Width of the "first set channel" index; never narrower than one bit.
    function automatic int first_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tia_dl_cell.sv
// One latch channel: pending stage, output stage, per-channel clear and
// optional rising-edge capture of the set request.
// Optional feature macro: TIA_DL_BANK_EDGE_EN.
module tia_dl_cell (
    input  logic clk,
    input  logic r_n,
    input  logic in_bit,
    input  logic s1,
    input  logic s2,
    input  logic clr,
    output logic out,
    output logic set_evt
);

    logic pend_q, pend_d;
    logic out_q, out_d;
    logic cap;

`ifdef TIA_DL_BANK_EDGE_EN
    logic prev_q, prev_d;

    // Previous request value tracks in every cycle, independent of s1.
    always_comb begin
        prev_d = in_bit;
        cap    = in_bit & ~prev_q;
    end

    // Previous-request register for edge detection.
    always_ff @(posedge clk) begin
        if (!r_n) prev_q <= 1'b0;
        else      prev_q <= prev_d;
    end
`else
    // Level-sensitive capture: the request itself is the capture value.
    always_comb begin
        cap = in_bit;
    end
`endif

    // Set-only latching; transfer uses the pre-edge pending bit, clear wins.
    always_comb begin
        pend_d = pend_q;
        out_d  = out_q;
        if (s1) pend_d = pend_q | cap;
        if (s2) out_d  = out_q | pend_q;
        if (clr) begin
            pend_d = 1'b0;
            out_d  = 1'b0;
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!r_n) begin
            pend_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign out     = out_q;
    assign set_evt = out_d & ~out_q;

endmodule

// File: rtl/tia_dl_bank.sv
// Bank of N latch channels with summary outputs (any, lowest set index)
// and a saturating count of output set events.
// Optional feature macro: TIA_DL_BANK_EDGE_EN (rising-edge capture of in).
module tia_dl_bank
    import tia_dl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     r_n,
    input  logic [N-1:0]             in,
    input  logic                     s1,
    input  logic                     s2,
    input  logic [N-1:0]             clr,
    input  logic                     clr_cnt,
    output logic [N-1:0]             out,
    output logic                     any,
    output logic [first_w(N)-1:0]    first,
    output logic [CNT_W-1:0]         count
);

    localparam int          FW      = first_w(N);
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [N-1:0]     set_evt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      evt_sum;
    logic [31:0]      cnt_sum;

    for (genvar g = 0; g < N; g++) begin : g_cell
        tia_dl_cell u_cell (
            .clk     (clk),
            .r_n     (r_n),
            .in_bit  (in[g]),
            .s1      (s1),
            .s2      (s2),
            .clr     (clr[g]),
            .out     (out[g]),
            .set_evt (set_evt[g])
        );
    end

    assign any = |out;

    // Lowest-index set channel wins; scanning downward lets it overwrite.
    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (out[i]) first = FW'(i);
        end
    end

    // Add this edge's set events and clamp at the counter's maximum.
    always_comb begin
        evt_sum = 32'd0;
        for (int i = 0; i < N; i++) begin
            evt_sum = evt_sum + {31'd0, set_evt[i]};
        end
        cnt_sum = {{(32 - CNT_W){1'b0}}, count_q} + evt_sum;
        if (clr_cnt)                count_d = '0;
        else if (cnt_sum > CNT_MAX) count_d = CNT_MAX[CNT_W-1:0];
        else                        count_d = cnt_sum[CNT_W-1:0];
    end

    // Event counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!r_n) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_tia_dl_bank.sv
// Self-checking bench for tia_dl_bank: two instances (8-bit and 2-bit
// counters) share stimulus and are compared every cycle to a vector model.
module tb_tia_dl_bank;

    logic       clk = 1'b0;
    logic       r_n = 1'b0;
    logic [3:0] in_v = '0;
    logic       s1_v = 1'b0;
    logic       s2_v = 1'b0;
    logic [3:0] clr_v = '0;
    logic       clr_cnt_v = 1'b0;

    logic [3:0] out_a, out_b;
    logic       any_a, any_b;
    logic [1:0] first_a, first_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  cmp_en   = 1'b0;

    bit [3:0] m_pend = '0;
    bit [3:0] m_out  = '0;
    bit [3:0] m_prev = '0;
    int       m_cnt_a = 0;
    int       m_cnt_b = 0;

    always #5 clk = ~clk;

    tia_dl_bank #(.N(4), .CNT_W(8)) dut (
        .clk(clk), .r_n(r_n), .in(in_v), .s1(s1_v), .s2(s2_v),
        .clr(clr_v), .clr_cnt(clr_cnt_v),
        .out(out_a), .any(any_a), .first(first_a), .count(count_a)
    );

    tia_dl_bank #(.N(4), .CNT_W(2)) dut_s (
        .clk(clk), .r_n(r_n), .in(in_v), .s1(s1_v), .s2(s2_v),
        .clr(clr_v), .clr_cnt(clr_cnt_v),
        .out(out_b), .any(any_b), .first(first_b), .count(count_b)
    );

    function automatic bit [3:0] capture_of(bit [3:0] req, bit [3:0] prev);
`ifdef TIA_DL_BANK_EDGE_EN
        return req & ~prev;
`else
        return req | (prev & 4'b0000);
`endif
    endfunction

    function automatic bit [3:0] pend_next(bit [3:0] pend, bit [3:0] req, bit [3:0] prev,
                                           bit cap_en, bit [3:0] clr);
        bit [3:0] p;
        p = cap_en ? (pend | capture_of(req, prev)) : pend;
        return p & ~clr;
    endfunction

    function automatic bit [3:0] out_next(bit [3:0] o, bit [3:0] pend, bit xfer, bit [3:0] clr);
        bit [3:0] n;
        n = xfer ? (o | pend) : o;
        return n & ~clr;
    endfunction

    function automatic int sat_count(int old, int inc, int maxv, bit zero);
        if (zero) return 0;
        return (old + inc > maxv) ? maxv : old + inc;
    endfunction

    function automatic int lowest_set(bit [3:0] o);
        for (int i = 0; i < 4; i++) if (o[i]) return i;
        return 0;
    endfunction

    // Reference model advances on every rising edge from the applied inputs.
    always @(posedge clk) begin
        if (!r_n) begin
            m_pend  <= '0;
            m_out   <= '0;
            m_prev  <= '0;
            m_cnt_a <= 0;
            m_cnt_b <= 0;
        end else begin
            m_pend  <= pend_next(m_pend, in_v, m_prev, s1_v, clr_v);
            m_out   <= out_next(m_out, m_pend, s2_v, clr_v);
            m_prev  <= in_v;
            m_cnt_a <= sat_count(m_cnt_a, $countones(out_next(m_out, m_pend, s2_v, clr_v) & ~m_out),
                                 255, clr_cnt_v);
            m_cnt_b <= sat_count(m_cnt_b, $countones(out_next(m_out, m_pend, s2_v, clr_v) & ~m_out),
                                 3, clr_cnt_v);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("out_a",   32'(out_a),   32'(m_out));
            check_output("any_a",   32'(any_a),   32'(m_out != 4'b0));
            check_output("first_a", 32'(first_a), 32'(lowest_set(m_out)));
            check_output("count_a", 32'(count_a), 32'(m_cnt_a));
            check_output("out_b",   32'(out_b),   32'(m_out));
            check_output("first_b", 32'(first_b), 32'(lowest_set(m_out)));
            check_output("count_b", 32'(count_b), 32'(m_cnt_b));
        end
    end

    task automatic apply_stimulus(input logic [3:0] req, input logic cap, input logic xfer,
                                  input logic [3:0] clr, input logic ccnt, input logic rst_n);
        in_v      = req;
        s1_v      = cap;
        s2_v      = xfer;
        clr_v     = clr;
        clr_cnt_v = ccnt;
        r_n       = rst_n;
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply_stimulus(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check_output("rst_out",   32'(out_a),   32'h0);
        check_output("rst_any",   32'(any_a),   32'h0);
        check_output("rst_first", 32'(first_a), 32'h0);
        check_output("rst_count", 32'(count_a), 32'h0);

        // Capture then transfer: minimum two-edge latency.
        apply_stimulus(4'b0100, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        check_output("lat1_out", 32'(out_a), 32'h0);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("lat2_out",   32'(out_a),   32'h4);
        check_output("lat2_any",   32'(any_a),   32'h1);
        check_output("lat2_first", 32'(first_a), 32'h2);
        check_output("lat2_count", 32'(count_a), 32'h1);

        // Simultaneous strobes: new request reaches pend only.
        do_reset();
        apply_stimulus(4'b0001, 1'b1, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("both_out1", 32'(out_a), 32'h0);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("both_out2", 32'(out_a), 32'h1);

        // Clear overrides a simultaneous transfer.
        do_reset();
        apply_stimulus(4'b0011, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("clr_pre", 32'(out_a), 32'h3);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
        check_output("clr_out",   32'(out_a),   32'h2);
        check_output("clr_first", 32'(first_a), 32'h1);
        check_output("clr_count", 32'(count_a), 32'h2);

        // Saturation of the 2-bit counter over five set/clear rounds.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'b0001, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
            apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
            apply_stimulus(4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1);
        end
        check_output("sat_count_b", 32'(count_b), 32'h3);
        check_output("sat_count_a", 32'(count_a), 32'h5);
        apply_stimulus(4'b0000, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1);
        check_output("clrcnt_b", 32'(count_b), 32'h0);
        check_output("clrcnt_a", 32'(count_a), 32'h0);

        // Reset between capture and transfer discards the capture.
        do_reset();
        apply_stimulus(4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0000, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("midrst_out",   32'(out_a),   32'h0);
        check_output("midrst_count", 32'(count_a), 32'h0);

        // Held request after a clear: edge mode must not re-set channel 1.
        do_reset();
        apply_stimulus(4'b0010, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        check_output("hold_set", 32'(out_a), 32'h2);
        apply_stimulus(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 1'b0, 1'b1, 4'b0, 1'b0, 1'b1);
`ifdef TIA_DL_BANK_EDGE_EN
        check_output("hold_final", 32'(out_a), 32'h0);
`else
        check_output("hold_final", 32'(out_a), 32'h2);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] rc;
            for (int b = 0; b < 4; b++) rc[b] = ($urandom_range(7) == 0);
            apply_stimulus(4'($urandom), 1'($urandom), 1'($urandom), rc,
                           ($urandom_range(15) == 0), ($urandom_range(39) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
